// File: rtl/cpu_defs.sv
// Shared constants and the fetch FSM state encoding.
package cpu_defs;

    localparam int          XLEN         = 32;
    localparam logic [31:0] INSTR_STEP   = 32'd4;
    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_VEC = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BOOT  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DROP  = 3'd4
    } fetch_state_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch controller: drives the PC register's next address and
// write enable, issues one memory request at a time, fills the IF slot and
// applies branch/jump redirects from EX.
module fetch_unit
    import cpu_defs::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_write,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic            w_load;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_target;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_instr;

    assign w_pc_inc = pc + INSTR_STEP;
    assign w_target = word_align(redirect_target);

    assign if_valid = r_if_valid;
    assign if_pc    = r_if_pc;
    assign if_instr = r_if_instr;

    // Next-state, next-PC mux, memory request and slot-load decision.
    always_comb begin
        w_state_nxt = r_state;
        pc_write    = 1'b0;
        pc_next     = '0;
        imem_req    = 1'b0;
        imem_addr   = '0;
        w_load      = 1'b0;
        case (r_state)
            // One idle cycle lets the PC register come out of reset first.
            IDLE: begin
                w_state_nxt = BOOT;
            end
            // Reset vector 0xFFFF_FFFC + 4 wraps to address 0.
            BOOT: begin
                pc_write    = 1'b1;
                pc_next     = w_pc_inc;
                w_state_nxt = ISSUE;
            end
            ISSUE: begin
                if (redirect_valid) begin
                    pc_write = 1'b1;
                    pc_next  = w_target;
                end else if (!r_if_valid || if_ready) begin
                    imem_req    = 1'b1;
                    imem_addr   = pc;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_write    = 1'b1;
                    pc_next     = w_target;
                    // A response still in flight must be swallowed in DROP.
                    w_state_nxt = imem_rvalid ? ISSUE : DROP;
                end else if (imem_rvalid) begin
                    w_load      = 1'b1;
                    pc_write    = 1'b1;
                    pc_next     = w_pc_inc;
                    w_state_nxt = ISSUE;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    pc_write = 1'b1;
                    pc_next  = w_target;
                end
                if (imem_rvalid) begin
                    w_state_nxt = ISSUE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register and IF slot; a redirect flushes the slot in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= NOP;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= pc;
                r_if_instr <= imem_rdata;
            end else if (redirect_valid || if_ready) begin
                r_if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a PC register model and a
// fixed-latency instruction memory model.
module tb_fetch_unit;
    import cpu_defs::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 1;
    int m_cnt    = 0;
    logic [31:0] m_addr = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } slot_t;

    typedef struct packed {
        logic        pcw;
        logic [31:0] pn;
        logic        req;
        logic [31:0] addr;
        logic        ifv;
    } vec_t;

    logic [31:0] exp_req_q[$];
    slot_t       exp_slot_q[$];
    vec_t        boot_tbl[8];

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc              (pc),
        .pc_next         (pc_next),
        .pc_write        (pc_write),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed, address-dependent pattern.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A3C};
    endfunction

    // PC register model.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pc <= PC_RESET_VEC;
        else if (pc_write) pc <= pc_next;
    end

    // Instruction memory model: not reset, so an in-flight response survives.
    always @(posedge clk) begin
        if (imem_req) begin
            m_cnt  <= mem_lat;
            m_addr <= imem_addr;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign imem_rvalid = (m_cnt == 1);
    assign imem_rdata  = word_at(m_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Scoreboard: pop expected request addresses and consumed slots.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (imem_req) begin
                if (exp_req_q.size() == 0) chk("req_unexpected", imem_addr, 32'hDEAD_DEAD);
                else chk("req_addr", imem_addr, exp_req_q.pop_front());
            end
            if (if_valid && if_ready) begin
                if (exp_slot_q.size() == 0) begin
                    chk("slot_unexpected", if_pc, 32'hDEAD_DEAD);
                end else begin
                    slot_t s;
                    s = exp_slot_q.pop_front();
                    chk("slot_pc", if_pc, s.pc);
                    chk("slot_instr", if_instr, s.instr);
                end
            end
        end
    end

    // Assert reset, check reset outputs, release; returns at cycle 0 (IDLE).
    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        if_ready        = rdy;
        #1;
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, NOP);
        chk("rst_pc_write", {31'b0, pc_write}, 32'h0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic skip(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic end_scn(input string nm);
        #3;
        chk({nm, "_req_q_left"}, exp_req_q.size(), 32'h0);
        chk({nm, "_slot_q_left"}, exp_slot_q.size(), 32'h0);
        exp_req_q.delete();
        exp_slot_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        if_ready        = 1'b1;

        //               pcw   pc_next        req   addr           ifv
        boot_tbl[0] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        boot_tbl[1] = '{1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        boot_tbl[2] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};
        boot_tbl[3] = '{1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000, 1'b0};
        boot_tbl[4] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0004, 1'b1};
        boot_tbl[5] = '{1'b1, 32'h0000_0008, 1'b0, 32'h0000_0000, 1'b0};
        boot_tbl[6] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008, 1'b1};
        boot_tbl[7] = '{1'b1, 32'h0000_000C, 1'b0, 32'h0000_0000, 1'b0};

        // Boot and steady fetch, latency 1.
        mem_lat = 1;
        exp_req_q.push_back(32'h0);
        exp_req_q.push_back(32'h4);
        exp_req_q.push_back(32'h8);
        exp_slot_q.push_back('{32'h0, word_at(32'h0)});
        exp_slot_q.push_back('{32'h4, word_at(32'h4)});
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk($sformatf("boot%0d_pc_write", i), {31'b0, pc_write}, {31'b0, boot_tbl[i].pcw});
            chk($sformatf("boot%0d_pc_next", i), pc_next, boot_tbl[i].pn);
            chk($sformatf("boot%0d_imem_req", i), {31'b0, imem_req}, {31'b0, boot_tbl[i].req});
            chk($sformatf("boot%0d_imem_addr", i), imem_addr, boot_tbl[i].addr);
            chk($sformatf("boot%0d_if_valid", i), {31'b0, if_valid}, {31'b0, boot_tbl[i].ifv});
        end
        @(negedge clk);
        if_ready = 1'b0;
        #1;
        chk("boot_stop_req", {31'b0, imem_req}, 32'h0);
        chk("boot_stop_if_pc", if_pc, 32'h8);
        chk("boot_stop_if_instr", if_instr, word_at(32'h8));
        end_scn("boot");

        // ID stall: slot full with if_ready low holds fetch; then flush by redirect.
        exp_req_q.push_back(32'h0);
        exp_req_q.push_back(32'h4);
        exp_req_q.push_back(32'h200);
        exp_slot_q.push_back('{32'h0, word_at(32'h0)});
        do_reset(1'b0);
        skip(3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("stall_req", {31'b0, imem_req}, 32'h0);
            chk("stall_pc", pc, 32'h4);
            chk("stall_if_valid", {31'b0, if_valid}, 32'h1);
            chk("stall_if_pc", if_pc, 32'h0);
            chk("stall_if_instr", if_instr, word_at(32'h0));
        end
        @(negedge clk);
        if_ready = 1'b1;
        #1;
        chk("stall_release_req", {31'b0, imem_req}, 32'h1);
        chk("stall_release_addr", imem_addr, 32'h4);
        skip(1);
        @(negedge clk);
        if_ready        = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        #1;
        chk("flush_if_valid_before", {31'b0, if_valid}, 32'h1);
        chk("flush_pc_write", {31'b0, pc_write}, 32'h1);
        chk("flush_pc_next", pc_next, 32'h200);
        chk("flush_req", {31'b0, imem_req}, 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("flush_if_valid_after", {31'b0, if_valid}, 32'h0);
        chk("flush_next_addr", imem_addr, 32'h200);
        end_scn("stall");

        // Redirect while waiting, latency 3: late response dropped.
        mem_lat = 3;
        exp_req_q.push_back(32'h0);
        exp_req_q.push_back(32'h100);
        do_reset(1'b1);
        skip(3);
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        #1;
        chk("wredir_pc_write", {31'b0, pc_write}, 32'h1);
        chk("wredir_pc_next", pc_next, 32'h100);
        chk("wredir_req", {31'b0, imem_req}, 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("drop_pc", pc, 32'h100);
        chk("drop_pc_write", {31'b0, pc_write}, 32'h0);
        @(negedge clk);
        #1;
        chk("drop_late_rvalid_pc_write", {31'b0, pc_write}, 32'h0);
        chk("drop_late_rvalid_req", {31'b0, imem_req}, 32'h0);
        @(negedge clk);
        #1;
        chk("drop_after_if_valid", {31'b0, if_valid}, 32'h0);
        chk("drop_after_req", {31'b0, imem_req}, 32'h1);
        chk("drop_after_addr", imem_addr, 32'h100);
        skip(3);
        #1;
        chk("drop_fill_pc_next", pc_next, 32'h104);
        @(negedge clk);
        if_ready = 1'b0;
        #1;
        chk("drop_fill_if_valid", {31'b0, if_valid}, 32'h1);
        chk("drop_fill_if_pc", if_pc, 32'h100);
        chk("drop_fill_if_instr", if_instr, word_at(32'h100));
        end_scn("drop");

        // Redirect coincident with response; unaligned target.
        mem_lat = 1;
        exp_req_q.push_back(32'h0);
        exp_req_q.push_back(32'h100);
        do_reset(1'b1);
        skip(3);
        redirect_valid  = 1'b1;
        redirect_target = 32'h103;
        #1;
        chk("coinc_pc_write", {31'b0, pc_write}, 32'h1);
        chk("coinc_pc_next", pc_next, 32'h100);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("coinc_if_valid", {31'b0, if_valid}, 32'h0);
        chk("coinc_addr", imem_addr, 32'h100);
        skip(1);
        @(negedge clk);
        if_ready = 1'b0;
        #1;
        chk("coinc_fill_if_pc", if_pc, 32'h100);
        chk("coinc_fill_if_instr", if_instr, word_at(32'h100));
        end_scn("coinc");

        // Wrap-around from the top word of the address space.
        exp_req_q.push_back(32'hFFFF_FFFC);
        exp_req_q.push_back(32'h0);
        exp_slot_q.push_back('{32'hFFFF_FFFC, word_at(32'hFFFF_FFFC)});
        do_reset(1'b1);
        skip(2);
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        #1;
        chk("wrap_issue_req", {31'b0, imem_req}, 32'h0);
        chk("wrap_pc_next", pc_next, 32'hFFFF_FFFC);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        chk("wrap_inc_pc_write", {31'b0, pc_write}, 32'h1);
        chk("wrap_inc_pc_next", pc_next, 32'h0);
        @(negedge clk);
        #1;
        chk("wrap_next_addr", imem_addr, 32'h0);
        chk("wrap_slot_pc", if_pc, 32'hFFFF_FFFC);
        skip(1);
        @(negedge clk);
        if_ready = 1'b0;
        #1;
        chk("wrap_end_pc", pc, 32'h4);
        chk("wrap_end_if_pc", if_pc, 32'h0);
        end_scn("wrap");

        // Reset during WAIT with a response in flight.
        mem_lat = 3;
        exp_req_q.push_back(32'h0);
        exp_req_q.push_back(32'h0);
        do_reset(1'b1);
        skip(3);
        rst_n = 1'b0;
        #1;
        chk("mrst_pc_write", {31'b0, pc_write}, 32'h0);
        chk("mrst_pc_next", pc_next, 32'h0);
        chk("mrst_req", {31'b0, imem_req}, 32'h0);
        chk("mrst_addr", imem_addr, 32'h0);
        chk("mrst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("mrst_pc", pc, PC_RESET_VEC);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst_idle_pc_write", {31'b0, pc_write}, 32'h0);
        @(negedge clk);
        #1;
        chk("mrst_boot_pc_write", {31'b0, pc_write}, 32'h1);
        chk("mrst_boot_pc_next", pc_next, 32'h0);
        @(negedge clk);
        #1;
        chk("mrst_issue_req", {31'b0, imem_req}, 32'h1);
        chk("mrst_issue_if_valid", {31'b0, if_valid}, 32'h0);
        skip(3);
        @(negedge clk);
        if_ready = 1'b0;
        #1;
        chk("mrst_fill_if_valid", {31'b0, if_valid}, 32'h1);
        chk("mrst_fill_if_pc", if_pc, 32'h0);
        chk("mrst_fill_if_instr", if_instr, word_at(32'h0));
        end_scn("mrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch controller that sits on the far side of the PC register. It consumes the PC register's current address and drives that register's next-address and write-enable inputs, closing the loop. It issues one instruction-memory request at a time, captures the returned word into an IF output slot for the IF/ID stage, and handles branch/jump redirects arriving from EX. The PC register itself has a reset value of 0xFFFF_FFFC; this block's boot step advances it to 0x0000_0000.

## Interface
- No parameters. Fixed constants: data/address width 32, `INSTR_STEP` = 4, `NOP` = 32'h0000_0000.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc`  in  32  current PC register output (address of the word being fetched).
- `pc_next`  out  32  next address, to the PC register's address input.
- `pc_write`  out  1  PC register write enable.
- `redirect_valid`  in  1  branch/jump taken, from EX.
- `redirect_target`  in  32  redirect address; bits [1:0] forced to 0.
- `imem_req`  out  1  one-cycle request strobe to instruction memory.
- `imem_addr`  out  32  request address.
- `imem_rvalid`  in  1  response strobe; latency ≥1 cycle, one outstanding request.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `if_valid`  out  1  IF slot holds an instruction.
- `if_ready`  in  1  IF/ID accepts the slot this cycle (low = ID stall).
- `if_pc`  out  32  address of the slot instruction.
- `if_instr`  out  32  slot instruction.

## Operation
- FSM states: IDLE, BOOT, ISSUE, WAIT, DROP. Reset state is IDLE.
- IDLE: all strobes low. Goes to BOOT unconditionally, which guarantees that the PC register is out of reset.
- BOOT: `pc_write`=1, `pc_next`=`pc`+4 (0xFFFF_FFFC wraps to 0). Then goes to ISSUE.
- ISSUE, in priority order:
  - If `redirect_valid`: `pc_write`=1, `pc_next`=target; no request; stay in ISSUE.
  - Else if the slot is free (`!if_valid || if_ready`): `imem_req`=1, `imem_addr`=`pc`; go to WAIT.
  - Else stay in ISSUE with no request.
- WAIT, in priority order:
  - If `redirect_valid` with `imem_rvalid`: discard the response; `pc_write`=1, `pc_next`=target; go to ISSUE.
  - If `redirect_valid` without `imem_rvalid`: `pc_write`=1, `pc_next`=target; go to DROP.
  - If `imem_rvalid` only: load the slot (`if_valid`←1, `if_pc`←`pc`, `if_instr`←`imem_rdata`); `pc_write`=1, `pc_next`=`pc`+4; go to ISSUE.
- DROP:
  - On `imem_rvalid`: discard the response, go to ISSUE.
  - On `redirect_valid`: `pc_write`=1, `pc_next`=new target, stay in DROP. If it coincides with `imem_rvalid`, still go to ISSUE.
- Slot:
  - `if_valid` clears when `if_ready`=1 and no new load happens that edge.
  - Any `redirect_valid` clears the slot (flush) at that edge, in every state.
  - Because a request is issued only when the slot is free or draining, a response never finds the slot occupied.
- Arithmetic: 32-bit unsigned; `pc`+4 wraps modulo 2^32.
- `pc_write`/`pc_next`/`imem_req`/`imem_addr` are combinational from state and inputs. When inactive: `pc_next`=0, `imem_addr`=0.

## Timing
- Reset (`rst_n` low, any state, any time): state=IDLE, `if_valid`=0, `if_pc`=0, `if_instr`=NOP. Combinational outputs are then 0. An outstanding memory response after reset is ignored because IDLE/BOOT do not sample `imem_rvalid`.
- Reset release to first `imem_req`: 2 cycles (IDLE, BOOT), then ISSUE with `pc`=0.
- Steady state without stalls: one instruction per (memory latency + 1) cycles. With latency 1: request in cycle n, rvalid in n+1, next request in n+2.
- `pc_write` pulse at edge E: the new `pc` is visible from the cycle after E. ISSUE always samples the updated `pc`.
- The slot load and the `if_valid` rise take effect at the edge where `imem_rvalid` is sampled.

## Structure
- Shared package/header `cpu_defs`: state encoding (IDLE=0, BOOT=1, ISSUE=2, WAIT=3, DROP=4), `INSTR_STEP`, `NOP`, `PC_RESET_VEC`=32'hFFFF_FFFC.
- Single module, no sub-modules. Next-PC mux and FSM in one combinational block; state and slot registers in one async-reset sequential block.

## Test plan
- Reset release with the PC model at 0xFFFF_FFFC, memory latency 1:
  - BOOT writes `pc_next`=0.
  - Requests at addresses 0, 4, 8 appear in the expected cycles.
  - `if_pc`/`if_instr` match the memory contents.
- `if_ready` held low for 5 cycles after the slot fills: no `imem_req`, `pc` held at 4, slot stable. On release, address 4 is requested.
- `redirect_valid` (target 0x100) in WAIT with memory latency 3: DROP is entered, the late response is discarded, the next request goes to 0x100, and `if_valid` was cleared.
- `redirect_valid` coincident with `imem_rvalid`: response not loaded; next request goes to the target. Target 0x103 is issued as 0x100.
- Wrap-around: redirect to 0xFFFF_FFFC, fetch it, then the next request is 0x0000_0000.
- `rst_n` asserted in WAIT with a response pending: outputs reach reset values immediately. A post-release response is ignored, and the boot sequence repeats.
